// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and sizing helpers for the serial subtractor
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  function automatic int slice_count(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_width(input int nslice);
    return $clog2(nslice + 1);
  endfunction

endpackage

// File: rtl/sub_slice.sv
// rtl/sub_slice.sv - one DIGIT-bit subtract step: xs + ~ys + cin
module sub_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] xs,
  input  logic [DIGIT-1:0] ys,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  localparam int SW = DIGIT + 1;

  // carry here is the inverted borrow
  assign {cout, s} = {1'b0, xs} + {1'b0, ~ys} + SW'(cin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial signed subtractor df = x - y - bin with valid/ready
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] df,
  output logic             bout,
  output logic             ovf,
  output logic             df_zero
);

  localparam int NSLICE = slice_count(WIDTH, DIGIT);
  localparam int CW     = cnt_width(NSLICE);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
  end

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] xs_q, ys_q, res_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             x_msb_q, y_msb_q;
  logic             ready_en_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] df_q;
  logic             bout_q, ovf_q, zero_q;

  logic [DIGIT-1:0] slice_s;
  logic             slice_c;

  logic accept, step, present;

  sub_slice #(.DIGIT(DIGIT)) u_slice (
    .xs   (xs_q[DIGIT-1:0]),
    .ys   (ys_q[DIGIT-1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_c)
  );

  assign in_ready = ready_en_q && (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign step     = (state_q == RUN);
  // flags are latched one cycle after the last slice so they are stable while out_valid is high
  assign present  = (state_q == DONE) && !out_valid_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (cnt_q == CW'(NSLICE - 1)) state_d = DONE;
      DONE: if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs_q    <= '0;
      ys_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      x_msb_q <= 1'b0;
      y_msb_q <= 1'b0;
    end else if (accept) begin
      xs_q    <= x;
      ys_q    <= y;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= ~bin;
      x_msb_q <= x[WIDTH-1];
      y_msb_q <= y[WIDTH-1];
    end else if (step) begin
      xs_q    <= xs_q >> DIGIT;
      ys_q    <= ys_q >> DIGIT;
      res_q   <= (res_q >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));
      carry_q <= slice_c;
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      df_q        <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (present) begin
      out_valid_q <= 1'b1;
      df_q        <= res_q;
      bout_q      <= ~carry_q;
      ovf_q       <= (x_msb_q != y_msb_q) && (res_q[WIDTH-1] != x_msb_q);
      zero_q      <= (res_q == '0);
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign df        = df_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign df_zero   = zero_q;

endmodule
